// File: rtl/rps_pkg.sv
// Shared types for the rock-paper-scissors match block: move and result
// encodings as they appear on the pins, plus the controller states.
package rps_pkg;

   // Player move as it arrives on the low two bits of PRIMO/SECONDO
   typedef enum logic [1:0] {
      NONE     = 2'b00,
      ROCK     = 2'b01,
      PAPER    = 2'b10,
      SCISSORS = 2'b11
   } move_t;

   // Shared encoding for the manche result and the match result
   typedef enum logic [1:0] {
      R_NONE = 2'b00,
      R_P1   = 2'b01,
      R_P2   = 2'b10,
      R_DRAW = 2'b11
   } result_t;

   // Match controller states
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PLAY = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/rps_match_fsmd_if.sv
// Command/result bundle between the player encoders, the match block and
// the result display. The master drives commands and moves; the slave (the
// match block) drives the registered results.
interface rps_match_fsmd_if #(
   parameter int SETUP_W = 4,
   parameter int CNT_W   = 5
);

   logic                   INIZIO_SETUP;
   logic                   INIZIO_CONTO;
   logic                   FINE_CONTO;
   logic [SETUP_W/2-1:0]   PRIMO;
   logic [SETUP_W/2-1:0]   SECONDO;
   logic [1:0]             MANCHE;
   logic [1:0]             PARTITA;
   logic [CNT_W-1:0]       PLAYED;

   modport master (
      output INIZIO_SETUP, INIZIO_CONTO, FINE_CONTO, PRIMO, SECONDO,
      input  MANCHE, PARTITA, PLAYED
   );

   modport slave (
      input  INIZIO_SETUP, INIZIO_CONTO, FINE_CONTO, PRIMO, SECONDO,
      output MANCHE, PARTITA, PLAYED
   );

endinterface

// File: rtl/rps_match_fsmd_judge.sv
// Combinational referee for a single manche: two moves in, one result out.
// Any invalid move makes the whole manche invalid.
module rps_judge
   import rps_pkg::*;
(
   input  move_t   p1Move_i,
   input  move_t   p2Move_i,
   output result_t result_o
);

   // Rock beats scissors, scissors beat paper, paper beats rock
   always_comb begin
      result_o = R_NONE;
      if (p1Move_i == NONE || p2Move_i == NONE) begin
         result_o = R_NONE;
      end else if (p1Move_i == p2Move_i) begin
         result_o = R_DRAW;
      end else if ((p1Move_i == ROCK     && p2Move_i == SCISSORS) ||
                   (p1Move_i == SCISSORS && p2Move_i == PAPER)    ||
                   (p1Move_i == PAPER    && p2Move_i == ROCK)) begin
         result_o = R_P1;
      end else begin
         result_o = R_P2;
      end
   end

endmodule

// File: rtl/rps_match_fsmd.sv
// Rock-paper-scissors match controller and datapath. Judges each manche,
// keeps both scores, the played counter and the match result, and closes
// the match on a lead/limit rule or on an explicit FINE_CONTO.
// Optional build macro RPS_NO_REPEAT_EN: the winner of the previous
// decisive manche may not replay the winning move in the next manche.
module rps_match_fsmd
   import rps_pkg::*;
#(
   parameter int MIN_ROUNDS = 4,
   parameter int SETUP_W    = 4,
   parameter int WIN_LEAD   = 2,
   parameter int CNT_W      = $clog2(MIN_ROUNDS + 2**SETUP_W)
)(
   input logic             clk,
   input logic             rst_n,
   rps_match_fsmd_if.slave bus
);

   state_t           state_q, state_d;
   result_t          manche_q, manche_d;
   result_t          partita_q, partita_d;
   logic [CNT_W-1:0] played_q, played_d;
   logic [CNT_W-1:0] score1_q, score1_d;
   logic [CNT_W-1:0] score2_q, score2_d;
   logic [CNT_W-1:0] maxRounds_q, maxRounds_d;
   logic [CNT_W-1:0] leadAbs;

   move_t            p1Move;
   move_t            p2Move;
   result_t          judgeRes;
   logic             repeatViolation;

   assign p1Move = move_t'(bus.PRIMO[1:0]);
   assign p2Move = move_t'(bus.SECONDO[1:0]);

   rps_judge u_judge (
      .p1Move_i (p1Move),
      .p2Move_i (p2Move),
      .result_o (judgeRes)
   );

`ifdef RPS_NO_REPEAT_EN
   logic  lastWinValid_q, lastWinValid_d;
   logic  lastWinP2_q, lastWinP2_d;
   move_t lastWinMove_q, lastWinMove_d;

   // A manche is void if last manche's winner plays the same winning move
   assign repeatViolation = lastWinValid_q &&
                            (lastWinP2_q ? (p2Move == lastWinMove_q)
                                         : (p1Move == lastWinMove_q));
`else
   assign repeatViolation = 1'b0;
`endif

   // Match result from the current scores: leader, or tie when level
   function automatic result_t leaderOf(input logic [CNT_W-1:0] s1,
                                        input logic [CNT_W-1:0] s2);
      if (s1 > s2)      return R_P1;
      else if (s2 > s1) return R_P2;
      else              return R_DRAW;
   endfunction

   // Next-state and datapath update; setup overrides everything, then
   // FINE_CONTO, then INIZIO_CONTO
   always_comb begin
      state_d     = state_q;
      manche_d    = manche_q;
      partita_d   = partita_q;
      played_d    = played_q;
      score1_d    = score1_q;
      score2_d    = score2_q;
      maxRounds_d = maxRounds_q;
      leadAbs     = '0;
`ifdef RPS_NO_REPEAT_EN
      lastWinValid_d = lastWinValid_q;
      lastWinP2_d    = lastWinP2_q;
      lastWinMove_d  = lastWinMove_q;
`endif
      if (bus.INIZIO_SETUP) begin
         maxRounds_d = CNT_W'(MIN_ROUNDS) + CNT_W'({bus.SECONDO, bus.PRIMO});
         played_d    = '0;
         score1_d    = '0;
         score2_d    = '0;
         manche_d    = R_NONE;
         partita_d   = R_NONE;
         state_d     = PLAY;
`ifdef RPS_NO_REPEAT_EN
         lastWinValid_d = 1'b0;
         lastWinP2_d    = 1'b0;
         lastWinMove_d  = NONE;
`endif
      end else begin
         case (state_q)
            PLAY: begin
               if (bus.FINE_CONTO) begin
                  state_d   = DONE;
                  manche_d  = R_NONE;
                  partita_d = leaderOf(score1_q, score2_q);
               end else if (bus.INIZIO_CONTO) begin
                  if (judgeRes == R_NONE || repeatViolation) begin
                     manche_d = R_NONE;
                  end else begin
                     manche_d = judgeRes;
                     played_d = played_q + 1'b1;
                     if (judgeRes == R_P1) score1_d = score1_q + 1'b1;
                     if (judgeRes == R_P2) score2_d = score2_q + 1'b1;
`ifdef RPS_NO_REPEAT_EN
                     lastWinValid_d = (judgeRes != R_DRAW);
                     lastWinP2_d    = (judgeRes == R_P2);
                     lastWinMove_d  = (judgeRes == R_P2) ? p2Move : p1Move;
`endif
                     leadAbs = (score1_d >= score2_d) ? (score1_d - score2_d)
                                                      : (score2_d - score1_d);
                     if ((played_d >= CNT_W'(MIN_ROUNDS) &&
                          leadAbs >= CNT_W'(WIN_LEAD)) ||
                         played_d == maxRounds_q) begin
                        state_d   = DONE;
                        partita_d = leaderOf(score1_d, score2_d);
                     end
                  end
               end
            end
            DONE: begin
               manche_d = R_NONE;
            end
            default: begin
            end
         endcase
      end
   end

   // State and datapath registers; reset abandons any match in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         manche_q    <= R_NONE;
         partita_q   <= R_NONE;
         played_q    <= '0;
         score1_q    <= '0;
         score2_q    <= '0;
         maxRounds_q <= CNT_W'(MIN_ROUNDS);
      end else begin
         state_q     <= state_d;
         manche_q    <= manche_d;
         partita_q   <= partita_d;
         played_q    <= played_d;
         score1_q    <= score1_d;
         score2_q    <= score2_d;
         maxRounds_q <= maxRounds_d;
      end
   end

`ifdef RPS_NO_REPEAT_EN
   // Remembers who won the last decisive manche and with which move
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lastWinValid_q <= 1'b0;
         lastWinP2_q    <= 1'b0;
         lastWinMove_q  <= NONE;
      end else begin
         lastWinValid_q <= lastWinValid_d;
         lastWinP2_q    <= lastWinP2_d;
         lastWinMove_q  <= lastWinMove_d;
      end
   end
`endif

   assign bus.MANCHE  = manche_q;
   assign bus.PARTITA = partita_q;
   assign bus.PLAYED  = played_q;

endmodule

// File: tb/tb_rps_match_fsmd.sv
// Testbench for rps_match_fsmd: table of directed vectors, a few hand
// sequences for reset behaviour, then randomized commands checked against
// a behavioural match model. Honors RPS_NO_REPEAT_EN when defined.
module tb_rps_match_fsmd;

   localparam int MIN_ROUNDS = 4;
   localparam int SETUP_W    = 4;
   localparam int WIN_LEAD   = 2;
   localparam int CNT_W      = $clog2(MIN_ROUNDS + 2**SETUP_W);

   logic clk;
   logic rst_n;

   rps_match_fsmd_if #(.SETUP_W(SETUP_W), .CNT_W(CNT_W)) bus ();

   rps_match_fsmd #(
      .MIN_ROUNDS (MIN_ROUNDS),
      .SETUP_W    (SETUP_W),
      .WIN_LEAD   (WIN_LEAD),
      .CNT_W      (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nChecks = 0;
   int nErrors = 0;

   typedef struct {
      string      name;
      logic       setup;
      logic       conto;
      logic       fine;
      logic [1:0] p;
      logic [1:0] s;
      int         expManche;
      int         expPartita;
      int         expPlayed;
   } vec_t;

   vec_t vecs[$];

   // Behavioural match model: phase 0 idle, 1 playing, 2 closed
   int mPhase, mS1, mS2, mPlayed, mMax, mManche, mPartita;
   int mLastWho, mLastMove;

   function automatic int judge(input int a, input int b);
      int d;
      if (a == 0 || b == 0) return 0;
      d = (a - b + 3) % 3;
      if (d == 0) return 3;
      if (d == 1) return 1;
      return 2;
   endfunction

   function automatic int leader(input int a, input int b);
      if (a > b) return 1;
      if (b > a) return 2;
      return 3;
   endfunction

   task automatic modelReset();
      mPhase = 0; mS1 = 0; mS2 = 0; mPlayed = 0; mMax = MIN_ROUNDS;
      mManche = 0; mPartita = 0; mLastWho = 0; mLastMove = 0;
   endtask

   task automatic modelStep(input logic setup, input logic conto,
                            input logic fine, input int p, input int s);
      int r;
      bit banned;
      if (setup) begin
         mMax = MIN_ROUNDS + s * 4 + p;
         mS1 = 0; mS2 = 0; mPlayed = 0; mManche = 0; mPartita = 0;
         mLastWho = 0; mLastMove = 0; mPhase = 1;
      end else if (mPhase == 1 && fine) begin
         mPhase = 2; mManche = 0; mPartita = leader(mS1, mS2);
      end else if (mPhase == 1 && conto) begin
         r = judge(p, s);
         banned = 0;
`ifdef RPS_NO_REPEAT_EN
         banned = (mLastWho == 1 && p == mLastMove) ||
                  (mLastWho == 2 && s == mLastMove);
`endif
         if (r == 0 || banned) begin
            mManche = 0;
         end else begin
            mManche = r;
            mPlayed++;
            if (r == 1) mS1++;
            if (r == 2) mS2++;
            mLastWho  = (r == 3) ? 0 : r;
            mLastMove = (r == 1) ? p : (r == 2) ? s : 0;
            if ((mPlayed >= MIN_ROUNDS &&
                 (mS1 - mS2 >= WIN_LEAD || mS2 - mS1 >= WIN_LEAD)) ||
                mPlayed == mMax) begin
               mPhase = 2;
               mPartita = leader(mS1, mS2);
            end
         end
      end else if (mPhase == 2) begin
         mManche = 0;
      end
   endtask

   // Drives one cycle of commands (called at a falling edge), advances
   // the model, and returns at the next falling edge ready for sampling
   task automatic applyStimulus(input logic setup, input logic conto,
                                input logic fine, input logic [1:0] p,
                                input logic [1:0] s);
      bus.INIZIO_SETUP = setup;
      bus.INIZIO_CONTO = conto;
      bus.FINE_CONTO   = fine;
      bus.PRIMO        = p;
      bus.SECONDO      = s;
      modelStep(setup, conto, fine, int'(p), int'(s));
      @(posedge clk);
      @(negedge clk);
      bus.INIZIO_SETUP = 1'b0;
      bus.INIZIO_CONTO = 1'b0;
      bus.FINE_CONTO   = 1'b0;
   endtask

   task automatic checkOutput(input string name, input int expManche,
                              input int expPartita, input int expPlayed);
      nChecks++;
      if (int'(bus.MANCHE) != expManche) begin
         nErrors++;
         $display("[TB] FAIL %s MANCHE: got %0d, expected %0d", name, bus.MANCHE, expManche);
      end
      nChecks++;
      if (int'(bus.PARTITA) != expPartita) begin
         nErrors++;
         $display("[TB] FAIL %s PARTITA: got %0d, expected %0d", name, bus.PARTITA, expPartita);
      end
      nChecks++;
      if (int'(bus.PLAYED) != expPlayed) begin
         nErrors++;
         $display("[TB] FAIL %s PLAYED: got %0d, expected %0d", name, bus.PLAYED, expPlayed);
      end
   endtask

   task automatic addVec(input string name, input logic setup, input logic conto,
                         input logic fine, input logic [1:0] p, input logic [1:0] s,
                         input int m, input int pt, input int pl);
      vec_t v;
      v.name = name; v.setup = setup; v.conto = conto; v.fine = fine;
      v.p = p; v.s = s; v.expManche = m; v.expPartita = pt; v.expPlayed = pl;
      vecs.push_back(v);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.INIZIO_SETUP = 1'b0;
      bus.INIZIO_CONTO = 1'b0;
      bus.FINE_CONTO   = 1'b0;
      bus.PRIMO        = '0;
      bus.SECONDO      = '0;
      modelReset();

      // Idle commands ignored, then a lead-closed match
      addVec("idle_conto", 0, 1, 0, 2'b10, 2'b01, 0, 0, 0);
      addVec("idle_fine",  0, 0, 1, 2'b00, 2'b00, 0, 0, 0);
      addVec("t2_setup",   1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
      addVec("t2_m1",      0, 1, 0, 2'b10, 2'b01, 1, 0, 1);
      addVec("t2_m2",      0, 1, 0, 2'b11, 2'b10, 1, 0, 2);
      addVec("t2_m3",      0, 1, 0, 2'b10, 2'b10, 3, 0, 3);
      addVec("t2_m4",      0, 1, 0, 2'b01, 2'b01, 3, 1, 4);
      addVec("t2_done",    0, 1, 0, 2'b10, 2'b01, 0, 1, 4);
      // Limit-closed match ending in a tie
      addVec("t3_setup",   1, 0, 0, 2'b01, 2'b00, 0, 0, 0);
      addVec("t3_inval",   0, 1, 0, 2'b00, 2'b11, 0, 0, 0);
      addVec("t3_m1",      0, 1, 0, 2'b11, 2'b10, 1, 0, 1);
      addVec("t3_m2",      0, 1, 0, 2'b10, 2'b11, 2, 0, 2);
      addVec("t3_m3",      0, 1, 0, 2'b01, 2'b01, 3, 0, 3);
      addVec("t3_m4",      0, 1, 0, 2'b11, 2'b01, 2, 0, 4);
      addVec("t3_m5",      0, 1, 0, 2'b01, 2'b11, 1, 3, 5);
      // Forced close beats a same-cycle manche
      addVec("t4_setup",   1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
      addVec("t4_m1",      0, 1, 0, 2'b01, 2'b11, 1, 0, 1);
      addVec("t4_fine",    0, 1, 1, 2'b10, 2'b01, 0, 1, 1);
      // Setup beats a same-cycle manche mid-match
      addVec("t5_setup",   1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
      addVec("t5_m1",      0, 1, 0, 2'b01, 2'b11, 1, 0, 1);
      addVec("t5_resetup", 1, 1, 0, 2'b10, 2'b01, 0, 0, 0);
      addVec("t5_m2",      0, 1, 0, 2'b10, 2'b01, 1, 0, 1);

      repeat (2) @(negedge clk);
      checkOutput("reset", 0, 0, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].setup, vecs[i].conto, vecs[i].fine, vecs[i].p, vecs[i].s);
         checkOutput(vecs[i].name, vecs[i].expManche, vecs[i].expPartita, vecs[i].expPlayed);
      end

      // Asynchronous reset in the middle of a match clears outputs at once
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", 0, 0, 0);
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // No-repeat rule sequence
      applyStimulus(1, 0, 0, 2'b00, 2'b00);
      applyStimulus(0, 1, 0, 2'b10, 2'b01);
      checkOutput("t6_m1", 1, 0, 1);
      applyStimulus(0, 1, 0, 2'b10, 2'b11);
`ifdef RPS_NO_REPEAT_EN
      checkOutput("t6_repeat", 0, 0, 1);
      applyStimulus(0, 1, 0, 2'b01, 2'b11);
      checkOutput("t6_m2", 1, 0, 2);
`else
      checkOutput("t6_repeat", 2, 0, 2);
      applyStimulus(0, 1, 0, 2'b01, 2'b11);
      checkOutput("t6_m2", 1, 0, 3);
`endif

      // Randomized commands against the model
      for (int i = 0; i < 600; i++) begin
         int sel;
         logic su, co, fi;
         sel = $urandom_range(0, 99);
         su = (sel < 5);
         fi = (sel >= 5 && sel < 10);
         co = (sel >= 10 && sel < 80) || ($urandom_range(0, 3) == 0);
         applyStimulus(su, co, fi, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         checkOutput("random", mManche, mPartita, mPlayed);
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
